display_scan_driver: RTL
========================

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed seven-segment digits (1..8).
REQ-002 SHALL have parameter IN_W, default 14, width of the unsigned binary input.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit scan slot (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port value  input  IN_W  unsigned binary number to display.
REQ-007 SHALL have port load  input  1  request to convert and latch value.
REQ-008 SHALL have port blank  input  1  1 = force display dark (all seg and an bits high).
REQ-009 SHALL have port lz_en  input  1  1 = suppress leading zeros.
REQ-010 SHALL have port dp_mask  input  DIGITS  bit i = 1 lights decimal point of digit i.
REQ-011 SHALL have port busy  output  1  conversion in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a new result is latched.
REQ-013 SHALL have port ovf  output  1  latched result exceeds 10^DIGITS-1.
REQ-014 SHALL have port seg  output  8  active-low segments, bit order {a,b,c,d,e,f,g,dp} MSB first.
REQ-015 SHALL have port an  output  DIGITS  active-low one-hot digit select; bit 0 = least significant digit.

Function
REQ-016 SHALL capture value when load=1 and busy=0 at a rising edge (edge k); load while busy=1 SHALL be ignored.
REQ-017 SHALL convert by iterative shift-add-3 (double dabble), one input bit per cycle, internal BCD wide enough for 2^IN_W-1.
REQ-018 SHALL hold busy=1 after edge k through edge k+IN_W; at edge k+IN_W+1 SHALL latch the BCD result, clear busy, assert done for exactly one cycle.
REQ-019 SHALL set ovf at latch time iff any BCD digit at position >= DIGITS is non-zero; ovf holds until the next latch.
REQ-020 SHALL keep displaying the previous latched result during a conversion (no tearing).
REQ-021 SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping; on the wrap edge the digit index SHALL advance i -> i+1, DIGITS-1 -> 0.
REQ-022 SHALL drive an with only bit [index] low when not blank; scanning continues while blank=1.
REQ-023 SHALL decode digit values 0..9 as hex 03,9F,25,0D,99,49,41,1F,01,09 (dp bit=1).
REQ-024 SHALL display dash (FD) on every digit when ovf=1, ignoring lz_en.
REQ-025 SHALL, with lz_en=1, blank (FF) every digit above the most significant non-zero digit; digit 0 always shown.
REQ-026 SHALL clear seg bit 0 for the current digit when dp_mask[index]=1, including on blanked-zero and dash digits.
REQ-027 SHALL output seg=FF and an all-ones when blank=1 or no result has been latched since reset.
REQ-028 SHALL register seg and an (one cycle after index change); no combinational path from inputs to outputs.

Reset
REQ-029 SHALL on rst=1 immediately set seg=FF, an all ones, busy=0, done=0, ovf=0, prescaler=0, index=0, result-valid=0, latched BCD=0.
REQ-030 SHALL abort any conversion in progress on reset; no done pulse follows; first load after rst deassertion starts fresh.

Verification (DIGITS=4, IN_W=14, SCAN_DIV=4)
REQ-031 SHALL cover: load value=1234, lz_en=0 -> busy 14 cycles, done at edge k+15, scan yields seg 99,0D,25,9F on an E,D,B,7.
REQ-032 SHALL cover: value=7, lz_en=1, dp_mask=0010 -> digit0 1F, digit1 FE, digits2/3 FF; with lz_en=0 digits1..3 = 03 (digit1 02).
REQ-033 SHALL cover: value=16383 -> ovf=1, all four digits FD; then value=9999 -> ovf=0, all digits 09.
REQ-034 SHALL cover: load at k, second load with value=5 at k+3 -> ignored; result 1234 latched; exactly one done pulse.
REQ-035 SHALL cover: rst pulsed mid-conversion at k+6 -> seg=FF, an=F immediately, busy=0, no done; next load of 42 converts normally.
REQ-036 SHALL cover: blank=1 with valid result -> seg=FF, an=F; index keeps advancing every 4 cycles; blank=0 resumes at current index.

Source files
------------

// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Converts an unsigned binary value to BCD with an iterative double-dabble
//   engine (one input bit per clock) and shows the latched result on a
//   multiplexed, active-low seven-segment display.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   value    in   [IN_W]   binary number to convert
//   load     in   start conversion (ignored while busy)
//   blank    in   force the display dark
//   lz_en    in   suppress leading zeros
//   dp_mask  in   [DIGITS] decimal point enable per digit
//   busy     out  conversion in progress
//   done     out  one-cycle pulse when a new result is latched
//   ovf      out  latched result does not fit in DIGITS digits
//   seg      out  [8] active-low {a,b,c,d,e,f,g,dp}
//   an       out  [DIGITS] active-low one-hot digit select, bit 0 = LSD
module display_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int IN_W     = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   value,
  input  logic              load,
  input  logic              blank,
  input  logic              lz_en,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  // Number of decimal digits needed for 2^w - 1.
  function automatic int calc_digits(input int w);
    longint maxv;
    longint p;
    int     n;
    maxv = (longint'(1) << w) - longint'(1);
    p    = longint'(10);
    n    = 1;
    for (int j = 0; j < 20; j++) begin
      if (p <= maxv) begin
        n = n + 1;
        p = p * longint'(10);
      end
    end
    return n;
  endfunction

  localparam int BCD_RAW = calc_digits(IN_W);
  // Keep at least DIGITS nibbles so every displayed position exists.
  localparam int BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
  localparam int BCD_W   = 4 * BCD_N;
  localparam int CNT_W   = $clog2(IN_W + 1);
  localparam int PRE_W   = $clog2(SCAN_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift in.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                               input logic in_bit);
    logic [BCD_W-1:0] t;
    t = b;
    for (int i = 0; i < BCD_N; i++) begin
      if (t[4*i +: 4] >= 4'd5) begin
        t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      end
    end
    return {t[BCD_W-2:0], in_bit};
  endfunction

  // Digit glyph, active low, dp bit left dark.
  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h03;
      4'd1:    return 8'h9F;
      4'd2:    return 8'h25;
      4'd3:    return 8'h0D;
      4'd4:    return 8'h99;
      4'd5:    return 8'h49;
      4'd6:    return 8'h41;
      4'd7:    return 8'h1F;
      4'd8:    return 8'h01;
      4'd9:    return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  // Conversion FSM: capture, IN_W shift-add steps, then latch the result.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_CONV;
          sh_d    = value;
          bcd_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        bcd_d = dd_step(bcd_q, sh_q[IN_W-1]);
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_CONV;
        end
      end
      S_LATCH: begin
        // Result and overflow flag change together so the display never tears.
        res_d   = bcd_q;
        ovf_d   = |(bcd_q >> (4 * DIGITS));
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan prescaler, digit index and next registered segment/anode pattern.
  always_comb begin
    logic [3:0] cur;
    logic       dp_cur;
    logic       upper_zero;
    logic [7:0] glyph;
    pre_d      = pre_q + PRE_W'(1);
    idx_d      = idx_q;
    cur        = 4'd0;
    dp_cur     = 1'b0;
    upper_zero = 1'b1;
    glyph      = 8'hFF;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur    = res_q[4*i +: 4];
        dp_cur = dp_mask[i];
      end
      // Current digit is a leading zero if it and everything above it is 0.
      if ((i >= int'(idx_q)) && (res_q[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    if (ovf_q) begin
      glyph = 8'hFD;
    end else if (lz_en && (idx_q != IDX_W'(0)) && upper_zero) begin
      glyph = 8'hFF;
    end else begin
      glyph = decode(cur);
    end
    if (dp_cur) begin
      glyph[0] = 1'b0;
    end else begin
      glyph[0] = glyph[0];
    end
    if (!valid_q || blank) begin
      seg_d = 8'hFF;
      an_d  = '1;
    end else begin
      seg_d = glyph;
      an_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
